// File: rtl/seq_mult.sv
// seq_mult: radix-2 shift-add multiplier, one partial product per clock.
// The operand magnitudes are multiplied unsigned, and the sign is applied to the
// final accumulator when the result is registered into p.
// A request is accepted in IDLE. done pulses WIDTH+1 cycles after acceptance.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request; accepted only while idle
//   signed_mode  1: a, b, p are two's complement (honoured only when SIGNED_EN=1)
//   a, b         operands, sampled on an accepted start
//   busy         high while running or presenting the result
//   done         one-cycle pulse; p is valid from this cycle on
//   p            product, held until the next accepted start
module seq_mult #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;

  logic               eff_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] mcand_ext;

  assign eff_signed = signed_mode & SIGNED_EN;
  // The magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is still correct when the
  // value is read as unsigned.
  assign a_mag      = (eff_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag      = (eff_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign mcand_ext  = {{WIDTH{1'b0}}, mcand_q};

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = eff_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        // cnt runs 0..WIDTH-1 for the partial products. The cnt==WIDTH cycle applies
        // the sign and registers p on entry to DONE.
        if (cnt_q == CntW'(WIDTH)) begin
          p_d     = neg_q ? (~acc_q + 1'b1) : acc_q;
          state_d = StDone;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + (mcand_ext << cnt_q);
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign p    = p_q;

endmodule
